// File: rtl/calc_pkg.sv
// Shared opcodes, error codes, widths and the scheduler state encoding for the calculator datapath.
package calc_pkg;

  localparam int unsigned OPND_W = 16;
  localparam int unsigned RES_W  = 32;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DIV0    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // 17-bit add/subtract; ADD zero-extends the carry, SUB sign-extends the borrow.
  function automatic logic [RES_W-1:0] addsub_result(
    input logic              is_sub,
    input logic [OPND_W-1:0] a,
    input logic [OPND_W-1:0] b
  );
    logic [OPND_W:0] r;
    if (is_sub) begin
      r = {1'b0, a} - {1'b0, b};
      return {{(RES_W-OPND_W-1){r[OPND_W]}}, r};
    end else begin
      r = {1'b0, a} + {1'b0, b};
      return {{(RES_W-OPND_W-1){1'b0}}, r};
    end
  endfunction

endpackage

// File: rtl/alu_op_scheduler_op_timer.sv
// Clear/enable cycle counter; expired flags the last permitted WAIT cycle.
module op_timer #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/alu_op_scheduler.sv
// One-at-a-time operation sequencer: ADD/SUB in-block, MUL/DIV via external start/done units.
module alu_op_scheduler
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [OPND_W-1:0] req_a,
  input  logic [OPND_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [OPND_W-1:0] mul_a,
  output logic [OPND_W-1:0] mul_b,
  input  logic              mul_done,
  input  logic [RES_W-1:0]  mul_result,
  output logic              div_start,
  output logic [OPND_W-1:0] div_m,
  output logic [OPND_W-1:0] div_q,
  input  logic              div_done,
  input  logic [RES_W-1:0]  div_result
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [OPND_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [OPND_W-1:0] div_m_q, div_m_d, div_q_q, div_q_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              mul_start_q, mul_start_d;
  logic              div_start_q, div_start_d;
  logic              accept, fast_path, sel_done, expired;

  assign accept    = (state_q == ST_IDLE) && req_valid;
  assign fast_path = (req_op == OP_ADD) || (req_op == OP_SUB) ||
                     ((req_op == OP_DIV) && (req_b == '0));
  // Only the unit actually started is listened to; the other's done is ignored.
  assign sel_done  = (op_q == OP_MUL) ? mul_done : div_done;

  op_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_op_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_ISSUE),
    .enable (state_q == ST_WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = fast_path ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (sel_done || expired) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    div_m_d     = div_m_q;
    div_q_d     = div_q_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = req_op;
          if (req_op == OP_MUL) begin
            mul_a_d = req_a;
            mul_b_d = req_b;
          end
          if (req_op == OP_DIV) begin
            div_m_d = req_b;
            div_q_d = req_a;
          end
          if (fast_path) begin
            rsp_valid_d = 1'b1;
            if (req_op == OP_DIV) begin
              rsp_data_d = {req_a, {OPND_W{1'b1}}};
              rsp_err_d  = ERR_DIV0;
            end else begin
              rsp_data_d = addsub_result(req_op == OP_SUB, req_a, req_b);
              rsp_err_d  = ERR_OK;
            end
          end else begin
            mul_start_d = (req_op == OP_MUL);
            div_start_d = (req_op == OP_DIV);
          end
        end
      end
      ST_WAIT: begin
        if (sel_done) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = (op_q == OP_MUL) ? mul_result : div_result;
          rsp_err_d   = ERR_OK;
        end else if (expired) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = ERR_TIMEOUT;
        end
      end
      ST_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_ADD;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      div_m_q     <= '0;
      div_q_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_OK;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      op_q        <= op_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      div_m_q     <= div_m_d;
      div_q_q     <= div_q_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign div_start = div_start_q;
  assign div_m     = div_m_q;
  assign div_q     = div_q_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler with behavioural multiplier and divider models.
module tb_alu_op_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;
  logic        mul_start;
  logic [15:0] mul_a, mul_b;
  logic        mul_done = 1'b0;
  logic [31:0] mul_result = '0;
  logic        div_start;
  logic [15:0] div_m, div_q;
  logic        div_done = 1'b0;
  logic [31:0] div_result = '0;

  alu_op_scheduler #(.TIMEOUT_CYC(64), .TO_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .div_start(div_start), .div_m(div_m), .div_q(div_q),
    .div_done(div_done), .div_result(div_result)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Multiplier model: done L cycles after the start cycle; silent when mul_respond=0.
  int unsigned mul_lat     = 5;
  bit          mul_respond = 1'b1;
  int unsigned mcnt        = 0;
  always @(negedge clk) begin
    mul_done = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mul_done   = 1'b1;
        mul_result = 32'(mul_a) * 32'(mul_b);
      end
    end
    if (mul_start && mul_respond) mcnt = mul_lat;
  end

  // Divider model: start in T+1, done in T+18; not reset, so its late done can follow a reset.
  int unsigned dcnt = 0;
  always @(negedge clk) begin
    div_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        div_done   = 1'b1;
        div_result = {div_q % div_m, div_q / div_m};
      end
    end
    if (div_start) dcnt = 17;
  end

  int mul_starts = 0;
  int div_starts = 0;
  always @(posedge clk) begin
    if (mul_start) mul_starts++;
    if (div_start) div_starts++;
  end

  logic [33:0] sb_q[$];

  function automatic logic [33:0] ref_result(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    case (op)
      2'd0:    return {2'd0, 32'(a) + 32'(b)};
      2'd1:    return {2'd0, 32'(a) - 32'(b)};
      2'd2:    return {2'd0, 32'(a) * 32'(b)};
      default: return (b == 16'd0) ? {2'd1, a, 16'hFFFF} : {2'd0, a % b, a / b};
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit expect_to);
    int          n;
    int          exp_lat;
    logic [33:0] exp;
    logic [31:0] held_data;
    logic [1:0]  held_err;
    @(negedge clk);
    mul_starts = 0;
    div_starts = 0;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    if (expect_to) begin
      sb_q.push_back({2'd2, 32'd0});
      exp_lat = 66;
    end else begin
      sb_q.push_back(ref_result(op, a, b));
      if (op == 2'd2)                   exp_lat = int'(mul_lat) + 2;
      else if (op == 2'd3 && b != '0)   exp_lat = 19;
      else                              exp_lat = 1;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n = 1;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    check("latency", 32'(n), 32'(exp_lat));
    exp = sb_q.pop_front();
    check("rsp_data", rsp_data, exp[31:0]);
    check("rsp_err", 32'(rsp_err), 32'(exp[33:32]));
    if (op == 2'd3 && b != '0) begin
      check("div_m", 32'(div_m), 32'(b));
      check("div_q", 32'(div_q), 32'(a));
    end
    if (op == 2'd2) begin
      check("mul_a", 32'(mul_a), 32'(a));
      check("mul_b", 32'(mul_b), 32'(b));
    end
    held_data = rsp_data;
    held_err  = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, held_data);
      check("hold_err", 32'(rsp_err), 32'(held_err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_ack", 32'(busy), 32'd0);
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("mul_start_cnt", 32'(mul_starts), 32'((op == 2'd2) ? 1 : 0));
    check("div_start_cnt", 32'(div_starts), 32'((op == 2'd3 && b != '0) ? 1 : 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_starts"}, 32'({mul_start, div_start}), 32'd0);
    check({tag, "_operands"}, {mul_a, mul_b} | {div_m, div_q}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    do_op(2'd0, 16'hFFFF, 16'h0001, 0, 1'b0);
    do_op(2'd1, 16'h0003, 16'h0005, 0, 1'b0);
    do_op(2'd3, 16'd100,  16'd7,    0, 1'b0);
    do_op(2'd3, 16'h1234, 16'h0000, 0, 1'b0);
    do_op(2'd2, 16'h1234, 16'h0056, 0, 1'b0);

    mul_respond = 1'b0;
    do_op(2'd2, 16'h0011, 16'h0022, 0, 1'b1);
    mul_respond = 1'b1;
    mul_lat = 64;
    do_op(2'd2, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    mul_lat = 65;
    do_op(2'd2, 16'h0102, 16'h0304, 4, 1'b1);
    mul_lat = 5;

    do_op(2'd0, 16'h8000, 16'h8001, 10, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      do_op(op, 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 0, 1'b0);
    end

    // Reset while waiting on the divider; its done pulse lands after the reset.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd3; req_a = 16'd500; req_b = 16'd9;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midop_rst");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) check("late_done_ignored", {rsp_valid, busy}, 32'd0);
    end
    check("late_rsp_valid", 32'(rsp_valid), 32'd0);
    check("late_busy", 32'(busy), 32'd0);
    check("late_rsp_data", rsp_data, 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    do_op(2'd1, 16'h0000, 16'h0001, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
